pc_fetch_unit: RTL and testbench

- Program-counter register and instruction-fetch sequencer for the unpipelined MIPS core.
- Consumes the next-PC/PC-source pair produced by the next-PC logic.
- Drives a req/ack instruction-memory port and presents one instruction at a time to decode.
- Returns the current PC and PC+4 so the next-PC logic can compute the branch and jump target for the instruction being issued.

---
 rtl/pc_fetch_unit_if.sv | 10 +
 rtl/pc_fetch_unit.sv | 102 ++++++++++
 tb/tb_pc_fetch_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory req/ack port between the fetch unit (master) and memory (slave).
interface pc_fetch_unit_if;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_data;

  modport master (output o_imem_req, o_imem_addr, input  i_imem_ack, i_imem_data);
  modport slave  (input  o_imem_req, o_imem_addr, output i_imem_ack, i_imem_data);
endinterface

// File: rtl/pc_fetch_unit.sv
// PC register and req/ack instruction-fetch sequencer for the unpipelined core.
// Define PC_FETCH_PERF_CNT_EN to add fetch and redirect performance counters.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [31:0]        i_nextpc,
  input  logic               i_pcsrc,
  input  logic               i_stall,
  pc_fetch_unit_if.master    imem,
  output logic [31:0]        o_instr,
  output logic               o_instr_valid,
  output logic [31:0]        o_pc,
  output logic [31:0]        o_pc_plus4,
  output logic               o_fetch_err
`ifdef PC_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        o_fetch_cnt,
  output logic [31:0]        o_redirect_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, ERROR} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [15:0] tmo_cnt;
  logic        req;

  assign pc_plus4         = pc + 32'd4;
  assign o_pc             = pc;
  assign o_pc_plus4       = pc_plus4;
  assign imem.o_imem_req  = req;
  assign imem.o_imem_addr = pc & ~32'h3;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      pc             <= RESET_PC & ~32'h3;
      req            <= 1'b0;
      o_instr        <= 32'h0;
      o_instr_valid  <= 1'b0;
      o_fetch_err    <= 1'b0;
      tmo_cnt        <= 16'h0;
`ifdef PC_FETCH_PERF_CNT_EN
      o_fetch_cnt    <= 32'h0;
      o_redirect_cnt <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state   <= FETCH;
          req     <= 1'b1;
          tmo_cnt <= 16'h0;
        end
        FETCH: begin
          if (imem.i_imem_ack) begin
            o_instr       <= imem.i_imem_data;
            o_instr_valid <= 1'b1;
            req           <= 1'b0;
            tmo_cnt       <= 16'h0;
            state         <= ISSUE;
`ifdef PC_FETCH_PERF_CNT_EN
            o_fetch_cnt   <= o_fetch_cnt + 32'd1;
`endif
          end else if (tmo_cnt == TMO_LAST) begin
            // Last allowed wait cycle expired: give up permanently until reset.
            req         <= 1'b0;
            o_fetch_err <= 1'b1;
            state       <= ERROR;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        ISSUE: begin
          if (!i_stall) begin
            o_instr_valid <= 1'b0;
            req           <= 1'b1;
            tmo_cnt       <= 16'h0;
            state         <= FETCH;
            pc            <= i_pcsrc ? (i_nextpc & ~32'h3) : pc_plus4;
`ifdef PC_FETCH_PERF_CNT_EN
            if (i_pcsrc) o_redirect_cnt <= o_redirect_cnt + 32'd1;
`endif
          end
        end
        ERROR: begin
          req           <= 1'b0;
          o_instr_valid <= 1'b0;
          o_fetch_err   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench: dut_a (RESET_PC=0, TIMEOUT_CYC=4) and dut_b (RESET_PC=FFFF_FFFC).
module tb_pc_fetch_unit;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] a_nextpc = '0, b_nextpc = '0;
  logic        a_pcsrc = 1'b0, b_pcsrc = 1'b0;
  logic        a_stall = 1'b0, b_stall = 1'b1;
  logic [31:0] a_instr, a_pc, a_pc4, b_instr, b_pc, b_pc4;
  logic        a_valid, a_err, b_valid, b_err;
`ifdef PC_FETCH_PERF_CNT_EN
  logic [31:0] a_fcnt, a_rcnt, b_fcnt, b_rcnt;
`endif
  int checks = 0;
  int errors = 0;

  pc_fetch_unit_if imem_a ();
  pc_fetch_unit_if imem_b ();

  always #5 i_clk = ~i_clk;

  pc_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYC(4)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_nextpc(a_nextpc), .i_pcsrc(a_pcsrc),
    .i_stall(a_stall), .imem(imem_a), .o_instr(a_instr), .o_instr_valid(a_valid),
    .o_pc(a_pc), .o_pc_plus4(a_pc4), .o_fetch_err(a_err)
`ifdef PC_FETCH_PERF_CNT_EN
    , .o_fetch_cnt(a_fcnt), .o_redirect_cnt(a_rcnt)
`endif
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_nextpc(b_nextpc), .i_pcsrc(b_pcsrc),
    .i_stall(b_stall), .imem(imem_b), .o_instr(b_instr), .o_instr_valid(b_valid),
    .o_pc(b_pc), .o_pc_plus4(b_pc4), .o_fetch_err(b_err)
`ifdef PC_FETCH_PERF_CNT_EN
    , .o_fetch_cnt(b_fcnt), .o_redirect_cnt(b_rcnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    imem_a.i_imem_ack  = 1'b0;
    imem_a.i_imem_data = 32'h0;
    imem_b.i_imem_ack  = 1'b1;
    imem_b.i_imem_data = 32'h1234_5678;
    step();
    step();
    chk("rst_req",   {31'h0, imem_a.o_imem_req}, 32'h0);
    chk("rst_valid", {31'h0, a_valid}, 32'h0);
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_err",   {31'h0, a_err}, 32'h0);
    chk("rst_addr",  imem_a.o_imem_addr, 32'h0);
    chk("rst_pc_b",  b_pc, 32'hFFFF_FFFC);
    i_rst = 1'b0;

    // IDLE -> FETCH
    step();
    chk("f0_req",  {31'h0, imem_a.o_imem_req}, 32'h1);
    chk("f0_addr", imem_a.o_imem_addr, 32'h0);
    chk("b_f0_addr", imem_b.o_imem_addr, 32'hFFFF_FFFC);
    imem_a.i_imem_ack  = 1'b1;
    imem_a.i_imem_data = 32'h2008_0005;

    // FETCH -> ISSUE
    step();
    chk("i0_instr", a_instr, 32'h2008_0005);
    chk("i0_valid", {31'h0, a_valid}, 32'h1);
    chk("i0_pc",    a_pc, 32'h0);
    chk("i0_pc4",   a_pc4, 32'h4);
    chk("i0_req",   {31'h0, imem_a.o_imem_req}, 32'h0);
    chk("b_i0_pc",  b_pc, 32'hFFFF_FFFC);
    chk("b_wrap",   b_pc4, 32'h0);
    chk("b_instr",  b_instr, 32'h1234_5678);
    imem_a.i_imem_ack = 1'b0;
    b_stall = 1'b0;

    step();
    chk("f1_addr", imem_a.o_imem_addr, 32'h4);
    chk("f1_valid", {31'h0, a_valid}, 32'h0);
    chk("b_f1_addr", imem_b.o_imem_addr, 32'h0);
    chk("b_f1_req", {31'h0, imem_b.o_imem_req}, 32'h1);
    b_stall = 1'b1;
    imem_a.i_imem_ack  = 1'b1;
    imem_a.i_imem_data = 32'hAAAA_0001;

    step();
    chk("i1_pc", a_pc, 32'h4);
    imem_a.i_imem_ack = 1'b0;
    a_pcsrc  = 1'b1;
    a_nextpc = 32'h0000_0100;

    step();
    chk("f2_addr", imem_a.o_imem_addr, 32'h100);
    a_pcsrc = 1'b0;
    imem_a.i_imem_ack  = 1'b1;
    imem_a.i_imem_data = 32'hAAAA_0002;

    step();
    chk("i2_pc", a_pc, 32'h100);
    imem_a.i_imem_ack = 1'b0;
    a_pcsrc  = 1'b1;
    a_nextpc = 32'h0000_0042;

    // Redirect target low bits are dropped
    step();
    chk("f3_addr", imem_a.o_imem_addr, 32'h40);
    a_pcsrc = 1'b0;
    imem_a.i_imem_ack  = 1'b1;
    imem_a.i_imem_data = 32'hAAAA_0003;

    step();
    chk("i3_pc",  a_pc, 32'h40);
    chk("i3_pc4", a_pc4, 32'h44);
    imem_a.i_imem_ack = 1'b0;
    a_stall  = 1'b1;
    a_nextpc = 32'h0000_0800;

    for (int i = 0; i < 5; i++) begin
      a_pcsrc = ~a_pcsrc;
      imem_a.i_imem_ack  = ~imem_a.i_imem_ack;
      imem_a.i_imem_data = 32'hDEAD_0000 + 32'(i);
      step();
      chk("st_instr", a_instr, 32'hAAAA_0003);
      chk("st_pc",    a_pc, 32'h40);
      chk("st_valid", {31'h0, a_valid}, 32'h1);
      chk("st_req",   {31'h0, imem_a.o_imem_req}, 32'h0);
    end
`ifdef PC_FETCH_PERF_CNT_EN
    chk("fcnt", a_fcnt, 32'd4);
    chk("rcnt", a_rcnt, 32'd2);
`endif
    a_stall = 1'b0;
    a_pcsrc = 1'b0;
    imem_a.i_imem_ack = 1'b0;

    step();
    chk("f4_addr", imem_a.o_imem_addr, 32'h44);
    chk("f4_req",  {31'h0, imem_a.o_imem_req}, 32'h1);

    // Asynchronous reset between edges while fetching
    #3;
    i_rst = 1'b1;
    #1;
    chk("ar_req",   {31'h0, imem_a.o_imem_req}, 32'h0);
    chk("ar_valid", {31'h0, a_valid}, 32'h0);
    chk("ar_pc",    a_pc, 32'h0);
    chk("ar_instr", a_instr, 32'h0);
`ifdef PC_FETCH_PERF_CNT_EN
    chk("ar_fcnt", a_fcnt, 32'd0);
    chk("ar_rcnt", a_rcnt, 32'd0);
`endif
    step();
    i_rst = 1'b0;

    step();
    chk("t_req0", {31'h0, imem_a.o_imem_req}, 32'h1);
    step();
    step();
    step();
    chk("t_req3", {31'h0, imem_a.o_imem_req}, 32'h1);
    chk("t_err3", {31'h0, a_err}, 32'h0);
    step();
    chk("t_req4", {31'h0, imem_a.o_imem_req}, 32'h0);
    chk("t_err4", {31'h0, a_err}, 32'h1);

    imem_a.i_imem_ack  = 1'b1;
    imem_a.i_imem_data = 32'hBAD0_BAD0;
    step();
    step();
    step();
    chk("e_err",   {31'h0, a_err}, 32'h1);
    chk("e_req",   {31'h0, imem_a.o_imem_req}, 32'h0);
    chk("e_valid", {31'h0, a_valid}, 32'h0);
    chk("e_instr", a_instr, 32'h0);

    #2;
    i_rst = 1'b1;
    #1;
    chk("er_err", {31'h0, a_err}, 32'h0);
    step();
    i_rst = 1'b0;
    step();
    chk("er_req", {31'h0, imem_a.o_imem_req}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
